// File: rtl/gemm_uop_loop_pkg.sv
// Shared definitions for the GEMM micro-op loop sequencer: default widths,
// instruction field positions and the sequencer state encoding.
package gemm_uop_pkg;

  // Default widths shared with the uop SRAM and GEMM datapath
  localparam int UPC_W_DEF     = 13;
  localparam int ITER_W_DEF    = 14;
  localparam int ACC_IDX_W_DEF = 11;
  localparam int INP_IDX_W_DEF = 11;
  localparam int WGT_IDX_W_DEF = 10;
  localparam int INS_W_DEF     = 128;

  // Width-independent header bits of the instruction word
  localparam int F_OPCODE    = 0;
  localparam int F_POP_PREV  = 3;
  localparam int F_POP_NEXT  = 4;
  localparam int F_PUSH_PREV = 5;
  localparam int F_PUSH_NEXT = 6;
  localparam int F_RESET     = 7;
  localparam int F_UOP_BGN   = 8;

  // Field LSBs for the default widths (packed LSB-first)
  localparam int F_UOP_END   = F_UOP_BGN  + UPC_W_DEF;
  localparam int F_ITER_OUT  = F_UOP_END  + UPC_W_DEF + 1;
  localparam int F_ITER_IN   = F_ITER_OUT + ITER_W_DEF;
  localparam int F_DST_F_OUT = F_ITER_IN  + ITER_W_DEF;
  localparam int F_DST_F_IN  = F_DST_F_OUT + ACC_IDX_W_DEF;
  localparam int F_SRC_F_OUT = F_DST_F_IN  + ACC_IDX_W_DEF;
  localparam int F_SRC_F_IN  = F_SRC_F_OUT + INP_IDX_W_DEF;
  localparam int F_WGT_F_OUT = F_SRC_F_IN  + INP_IDX_W_DEF;
  localparam int F_WGT_F_IN  = F_WGT_F_OUT + WGT_IDX_W_DEF;
  localparam int F_TOTAL     = F_WGT_F_IN  + WGT_IDX_W_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/gemm_uop_loop_acc.sv
// loop_offset_acc: one index channel (dst, src or wgt) of the uop loop.
// Keeps the outer and inner offset pair and presents their wrapped sum.
module loop_offset_acc
  import gemm_uop_pkg::*;
#(
  parameter int W = ACC_IDX_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_step_in,
  input  logic         i_step_out,
  input  logic         i_wrap_in,
  input  logic [W-1:0] i_f_in,
  input  logic [W-1:0] i_f_out,
  output logic [W-1:0] o_sum
);

  logic [W-1:0] r_off_in;
  logic [W-1:0] r_off_out;

  // Offset pair: cleared on accept, stepped by the loop controller, wraps mod 2^W
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_off_in  <= '0;
      r_off_out <= '0;
    end else if (i_clear) begin
      r_off_in  <= '0;
      r_off_out <= '0;
    end else begin
      if (i_wrap_in)
        r_off_in <= '0;
      else if (i_step_in)
        r_off_in <= r_off_in + i_f_in;
      if (i_step_out)
        r_off_out <= r_off_out + i_f_out;
    end
  end

  assign o_sum = r_off_out + r_off_in;

endmodule

// File: rtl/gemm_uop_loop.sv
// gemm_uop_loop: runs one GEMM instruction's iter_out x iter_in x uop-range
// loop, emitting one beat per micro-op with back-pressure and a done pulse.
// Optional macro UOP_LOOP_PERF_EN builds the stall_cycles counter.
module gemm_uop_loop
  import gemm_uop_pkg::*;
#(
  parameter int UPC_W     = UPC_W_DEF,
  parameter int ITER_W    = ITER_W_DEF,
  parameter int ACC_IDX_W = ACC_IDX_W_DEF,
  parameter int INP_IDX_W = INP_IDX_W_DEF,
  parameter int WGT_IDX_W = WGT_IDX_W_DEF,
  parameter int INS_W     = INS_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 insn_valid,
  output logic                 insn_ready,
  input  logic [INS_W-1:0]     insn,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [UPC_W-1:0]     out_upc,
  output logic [ACC_IDX_W-1:0] out_dst,
  output logic [INP_IDX_W-1:0] out_src,
  output logic [WGT_IDX_W-1:0] out_wgt,
  output logic                 out_reset,
  output logic                 out_last,
  output logic                 done,
  output logic [31:0]          stall_cycles
);

  localparam int L_UOP_END   = F_UOP_BGN + UPC_W;
  localparam int L_ITER_OUT  = L_UOP_END + UPC_W + 1;
  localparam int L_ITER_IN   = L_ITER_OUT + ITER_W;
  localparam int L_DST_F_OUT = L_ITER_IN + ITER_W;
  localparam int L_DST_F_IN  = L_DST_F_OUT + ACC_IDX_W;
  localparam int L_SRC_F_OUT = L_DST_F_IN + ACC_IDX_W;
  localparam int L_SRC_F_IN  = L_SRC_F_OUT + INP_IDX_W;
  localparam int L_WGT_F_OUT = L_SRC_F_IN + INP_IDX_W;
  localparam int L_WGT_F_IN  = L_WGT_F_OUT + WGT_IDX_W;
  localparam int L_TOTAL     = L_WGT_F_IN + WGT_IDX_W;

  if (L_TOTAL > INS_W) begin : g_ins_w_check
    $error("INS_W too small for instruction fields");
  end

  state_e r_state, w_state_nxt;

  logic [UPC_W-1:0]     r_upc, r_uop_bgn;
  logic [UPC_W:0]       r_uop_end;
  logic [ITER_W-1:0]    r_iter_in, r_iter_out, r_iter_in_cfg, r_iter_out_cfg;
  logic                 r_reset;
  logic [ACC_IDX_W-1:0] r_dst_f_out, r_dst_f_in;
  logic [INP_IDX_W-1:0] r_src_f_out, r_src_f_in;
  logic [WGT_IDX_W-1:0] r_wgt_f_out, r_wgt_f_in;

  // Fields of the offered instruction; opcode and dependency flags are not used here
  logic [UPC_W-1:0]  w_ins_bgn;
  logic [UPC_W:0]    w_ins_end;
  logic [ITER_W-1:0] w_ins_iter_out, w_ins_iter_in;
  logic              w_unused_insn;
  assign w_ins_bgn      = insn[F_UOP_BGN +: UPC_W];
  assign w_ins_end      = insn[L_UOP_END +: UPC_W + 1];
  assign w_ins_iter_out = insn[L_ITER_OUT +: ITER_W];
  assign w_ins_iter_in  = insn[L_ITER_IN +: ITER_W];
  assign w_unused_insn  = ^insn;

  logic w_accept, w_empty, w_fire;
  logic w_end_upc, w_end_in, w_end_out, w_end_all;
  logic w_step_in, w_step_out;

  assign w_accept   = insn_valid && (r_state == IDLE);
  assign w_empty    = ({1'b0, w_ins_bgn} >= w_ins_end) ||
                      (w_ins_iter_in == '0) || (w_ins_iter_out == '0);
  assign w_fire     = (r_state == RUN) && out_ready;
  // upc compare is one bit wider so uop_end = 2^UPC_W terminates correctly
  assign w_end_upc  = (({1'b0, r_upc} + (UPC_W + 1)'(1)) == r_uop_end);
  assign w_end_in   = ((r_iter_in + ITER_W'(1)) == r_iter_in_cfg);
  assign w_end_out  = ((r_iter_out + ITER_W'(1)) == r_iter_out_cfg);
  assign w_end_all  = w_end_upc && w_end_in && w_end_out;
  assign w_step_in  = w_fire && w_end_upc && !w_end_in;
  assign w_step_out = w_fire && w_end_upc && w_end_in && !w_end_out;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM next state and handshake/status outputs
  always_comb begin
    w_state_nxt = r_state;
    insn_ready  = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        insn_ready = 1'b1;
        if (insn_valid) w_state_nxt = w_empty ? DONE : RUN;
      end
      RUN: begin
        out_valid = 1'b1;
        out_last  = w_end_all;
        if (out_ready && w_end_all) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latch the instruction on accept; advance upc and loop counters on each handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_upc <= '0; r_uop_bgn <= '0; r_uop_end <= '0;
      r_iter_in <= '0; r_iter_out <= '0; r_iter_in_cfg <= '0; r_iter_out_cfg <= '0;
      r_reset <= 1'b0;
      r_dst_f_out <= '0; r_dst_f_in <= '0;
      r_src_f_out <= '0; r_src_f_in <= '0;
      r_wgt_f_out <= '0; r_wgt_f_in <= '0;
    end else if (w_accept) begin
      r_upc          <= w_ins_bgn;
      r_uop_bgn      <= w_ins_bgn;
      r_uop_end      <= w_ins_end;
      r_iter_in      <= '0;
      r_iter_out     <= '0;
      r_iter_in_cfg  <= w_ins_iter_in;
      r_iter_out_cfg <= w_ins_iter_out;
      r_reset        <= insn[F_RESET];
      r_dst_f_out    <= insn[L_DST_F_OUT +: ACC_IDX_W];
      r_dst_f_in     <= insn[L_DST_F_IN +: ACC_IDX_W];
      r_src_f_out    <= insn[L_SRC_F_OUT +: INP_IDX_W];
      r_src_f_in     <= insn[L_SRC_F_IN +: INP_IDX_W];
      r_wgt_f_out    <= insn[L_WGT_F_OUT +: WGT_IDX_W];
      r_wgt_f_in     <= insn[L_WGT_F_IN +: WGT_IDX_W];
    end else if (w_fire) begin
      if (!w_end_upc) begin
        r_upc <= r_upc + UPC_W'(1);
      end else if (!w_end_in) begin
        r_upc     <= r_uop_bgn;
        r_iter_in <= r_iter_in + ITER_W'(1);
      end else if (!w_end_out) begin
        r_upc      <= r_uop_bgn;
        r_iter_in  <= '0;
        r_iter_out <= r_iter_out + ITER_W'(1);
      end
    end
  end

  loop_offset_acc #(.W(ACC_IDX_W)) u_dst (
    .clk(clk), .rst(rst), .i_clear(w_accept), .i_step_in(w_step_in),
    .i_step_out(w_step_out), .i_wrap_in(w_step_out),
    .i_f_in(r_dst_f_in), .i_f_out(r_dst_f_out), .o_sum(out_dst)
  );

  loop_offset_acc #(.W(INP_IDX_W)) u_src (
    .clk(clk), .rst(rst), .i_clear(w_accept), .i_step_in(w_step_in),
    .i_step_out(w_step_out), .i_wrap_in(w_step_out),
    .i_f_in(r_src_f_in), .i_f_out(r_src_f_out), .o_sum(out_src)
  );

  loop_offset_acc #(.W(WGT_IDX_W)) u_wgt (
    .clk(clk), .rst(rst), .i_clear(w_accept), .i_step_in(w_step_in),
    .i_step_out(w_step_out), .i_wrap_in(w_step_out),
    .i_f_in(r_wgt_f_in), .i_f_out(r_wgt_f_out), .o_sum(out_wgt)
  );

  assign out_upc   = r_upc;
  assign out_reset = r_reset;

`ifdef UOP_LOOP_PERF_EN
  logic [31:0] r_stall;

  // Count back-pressured RUN cycles, saturating; cleared when a new instruction is taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_stall <= '0;
    else if (w_accept)
      r_stall <= '0;
    else if ((r_state == RUN) && !out_ready && (r_stall != '1))
      r_stall <= r_stall + 32'd1;
  end

  assign stall_cycles = r_stall;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_gemm_uop_loop.sv
// Directed bench for gemm_uop_loop: loop order, offsets, wrap, back-pressure,
// zero-beat instructions, upc top-of-range and asynchronous reset mid-run.
module tb_gemm_uop_loop;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         insn_valid = 1'b0;
  logic         insn_ready;
  logic [127:0] insn = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [12:0]  out_upc;
  logic [10:0]  out_dst;
  logic [10:0]  out_src;
  logic [9:0]   out_wgt;
  logic         out_reset;
  logic         out_last;
  logic         done;
  logic [31:0]  stall_cycles;

  gemm_uop_loop dut (
    .clk(clk), .rst(rst),
    .insn_valid(insn_valid), .insn_ready(insn_ready), .insn(insn),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_upc(out_upc), .out_dst(out_dst), .out_src(out_src), .out_wgt(out_wgt),
    .out_reset(out_reset), .out_last(out_last), .done(done),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Beat log and timing of the most recent run
  logic [63:0] q_upc[$];
  logic [63:0] q_dst[$];
  logic [63:0] q_src[$];
  logic [63:0] q_wgt[$];
  int last_beat, last_cyc, first_cyc, done_cyc, ready_cyc;
  bit saw_valid, rr_seen;

  // Hand-computed sequences for bgn=4 end=7 iter_in=2 iter_out=2
  // dst_f_in=1 dst_f_out=10 src_f_in=3 src_f_out=100
  int E_UPC_A[12] = '{4, 5, 6, 4, 5, 6, 4, 5, 6, 4, 5, 6};
  int E_DST_A[12] = '{0, 0, 0, 1, 1, 1, 10, 10, 10, 11, 11, 11};
  int E_SRC_A[12] = '{0, 0, 0, 3, 3, 3, 100, 100, 100, 103, 103, 103};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk(input int bgn, input int endv, input int io, input int ii,
                                      input int dfo, input int dfi, input int sfo, input int sfi,
                                      input int wfo, input int wfi, input bit rr);
    logic [127:0] v;
    v = '0;
    v[2:0]     = 3'd2;
    v[7]       = rr;
    v[20:8]    = bgn[12:0];
    v[34:21]   = endv[13:0];
    v[48:35]   = io[13:0];
    v[62:49]   = ii[13:0];
    v[73:63]   = dfo[10:0];
    v[84:74]   = dfi[10:0];
    v[95:85]   = sfo[10:0];
    v[106:96]  = sfi[10:0];
    v[116:107] = wfo[9:0];
    v[126:117] = wfi[9:0];
    return v;
  endfunction

  task automatic offer(input logic [127:0] ins);
    int w;
    w = 0;
    while (!insn_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("insn_ready_before_accept", 64'(insn_ready), 64'(1));
    insn       = ins;
    insn_valid = 1'b1;
    @(negedge clk);
    insn_valid = 1'b0;
    insn       = '1;
  endtask

  // Offer one instruction and log beats until the block is ready again
  task automatic run(input logic [127:0] ins, input bit toggle);
    logic [63:0] h_upc, h_dst, h_src;
    bit held;
    q_upc.delete(); q_dst.delete(); q_src.delete(); q_wgt.delete();
    last_beat = -1; last_cyc = -1; first_cyc = -1; done_cyc = -1; ready_cyc = -1;
    saw_valid = 1'b0; rr_seen = 1'b0; held = 1'b0;
    h_upc = '0; h_dst = '0; h_src = '0;
    out_ready = 1'b1;
    offer(ins);
    for (int cyc = 1; cyc <= 80; cyc++) begin
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (held) begin
        check("hold_upc", 64'(out_upc), h_upc);
        check("hold_dst", 64'(out_dst), h_dst);
        check("hold_src", 64'(out_src), h_src);
        held = 1'b0;
      end
      if (out_valid && !saw_valid) begin
        saw_valid = 1'b1;
        first_cyc = cyc;
        rr_seen   = out_reset;
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      if (out_valid && out_ready) begin
        q_upc.push_back(64'(out_upc));
        q_dst.push_back(64'(out_dst));
        q_src.push_back(64'(out_src));
        q_wgt.push_back(64'(out_wgt));
        if (out_last) last_beat = q_upc.size();
        last_cyc = cyc;
      end else if (out_valid) begin
        h_upc = 64'(out_upc);
        h_dst = 64'(out_dst);
        h_src = 64'(out_src);
        held  = 1'b1;
      end
      if (done_cyc >= 0 && insn_ready) begin
        ready_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("run_completed", 64'(ready_cyc >= 0), 64'(1));
  endtask

  task automatic check_a(input string tag);
    check({tag, "_beats"}, 64'(q_upc.size()), 64'(12));
    for (int i = 0; i < 12 && i < q_upc.size(); i++) begin
      check($sformatf("%s_upc%0d", tag, i), q_upc[i], 64'(E_UPC_A[i]));
      check($sformatf("%s_dst%0d", tag, i), q_dst[i], 64'(E_DST_A[i]));
      check($sformatf("%s_src%0d", tag, i), q_src[i], 64'(E_SRC_A[i]));
    end
    check({tag, "_first_cyc"}, 64'(first_cyc), 64'(1));
    check({tag, "_last_beat"}, 64'(last_beat), 64'(12));
    check({tag, "_done_cyc"}, 64'(done_cyc), 64'(last_cyc + 1));
    check({tag, "_ready_cyc"}, 64'(ready_cyc), 64'(done_cyc + 1));
    check({tag, "_out_reset"}, 64'(rr_seen), 64'(1));
  endtask

  initial begin
    logic [127:0] ins_a;
    int nb;
    bit saw_done;
    ins_a = mk(4, 7, 2, 2, 10, 1, 100, 3, 0, 0, 1'b1);

    // Reset values
    #1;
    check("rst_insn_ready", 64'(insn_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_out_reset", 64'(out_reset), 64'(0));
    check("rst_out_upc", 64'(out_upc), 64'(0));
    check("rst_out_dst", 64'(out_dst), 64'(0));
    check("rst_out_src", 64'(out_src), 64'(0));
    check("rst_out_wgt", 64'(out_wgt), 64'(0));
    check("rst_stall", 64'(stall_cycles), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Full-throughput nested loop
    run(ins_a, 1'b0);
    check_a("full");

    // Same instruction with out_ready toggling
    run(ins_a, 1'b1);
    check_a("toggle");
`ifdef UOP_LOOP_PERF_EN
    check("toggle_stall_cycles", 64'(stall_cycles), 64'(12));
`else
    check("toggle_stall_cycles", 64'(stall_cycles), 64'(0));
`endif

    // Zero-beat: iter_in = 0
    run(mk(4, 7, 2, 0, 10, 1, 0, 0, 0, 0, 1'b0), 1'b0);
    check("zin_no_valid", 64'(saw_valid), 64'(0));
    check("zin_done_cyc", 64'(done_cyc), 64'(1));
    check("zin_ready_cyc", 64'(ready_cyc), 64'(2));

    // Zero-beat: bgn == end
    run(mk(5, 5, 2, 2, 0, 0, 0, 0, 0, 0, 1'b0), 1'b0);
    check("zrange_no_valid", 64'(saw_valid), 64'(0));
    check("zrange_done_cyc", 64'(done_cyc), 64'(1));
    check("zrange_ready_cyc", 64'(ready_cyc), 64'(2));

    // Weight offset wraps modulo 2^10
    run(mk(3, 4, 1, 3, 0, 0, 0, 0, 0, 1023, 1'b0), 1'b0);
    check("wrap_beats", 64'(q_wgt.size()), 64'(3));
    if (q_wgt.size() == 3) begin
      check("wrap_wgt0", q_wgt[0], 64'(0));
      check("wrap_wgt1", q_wgt[1], 64'(1023));
      check("wrap_wgt2", q_wgt[2], 64'(1022));
      check("wrap_upc2", q_upc[2], 64'(3));
    end
    check("wrap_out_reset", 64'(rr_seen), 64'(0));
    check("wrap_last_beat", 64'(last_beat), 64'(3));

    // uop_end at 2^UPC_W
    run(mk(8190, 8192, 1, 1, 0, 0, 0, 0, 0, 0, 1'b0), 1'b0);
    check("top_beats", 64'(q_upc.size()), 64'(2));
    if (q_upc.size() == 2) begin
      check("top_upc0", q_upc[0], 64'(8190));
      check("top_upc1", q_upc[1], 64'(8191));
    end
    check("top_last_beat", 64'(last_beat), 64'(2));

    // Asynchronous reset during beat 5
    offer(ins_a);
    nb = 0;
    for (int c = 0; c < 20 && nb < 4; c++) begin
      if (out_valid) nb++;
      @(negedge clk);
    end
    check("mid_pre_valid", 64'(out_valid), 64'(1));
    check("mid_pre_upc", 64'(out_upc), 64'(5));
    check("mid_pre_dst", 64'(out_dst), 64'(1));
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_ready", 64'(insn_ready), 64'(1));
    check("mid_rst_upc", 64'(out_upc), 64'(0));
    check("mid_rst_dst", 64'(out_dst), 64'(0));
    check("mid_rst_last", 64'(out_last), 64'(0));
    check("mid_rst_reset", 64'(out_reset), 64'(0));
    saw_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (c == 1) rst = 1'b1;
    end
    check("mid_no_done", 64'(saw_done), 64'(0));
    check("mid_idle_ready", 64'(insn_ready), 64'(1));

    // Instruction after the aborted run
    run(ins_a, 1'b0);
    check_a("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/gemm_uop_loop.md
# gemm_uop_loop

Parametrised GEMM micro-op loop sequencer, successor to the single-instruction free-running uop counter. Accepts one decoded GEMM instruction over a valid/ready handshake and runs the two-level loop (iter_out × iter_in × uop range) exactly once. Emits one beat per micro-op, carrying upc and the combined dst/src/wgt index offsets, with output back-pressure. Reports completion with a done pulse. Sits between the instruction queue and the uop SRAM / GEMM datapath.

## Interface
- UPC_W, 13, micro-op pointer width; uop_end field is UPC_W+1 bits.
- ITER_W, 14, iter_out / iter_in count width.
- ACC_IDX_W, 11, dst (accumulator) index and factor width.
- INP_IDX_W, 11, src (input) index and factor width.
- WGT_IDX_W, 10, wgt (weight) index and factor width.
- INS_W, 128, instruction width; must be ≥ packed field total.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- insn_valid  in  1  instruction offered.
- insn_ready  out  1  block can accept an instruction (IDLE only).
- insn  in  INS_W  instruction. Fields are packed LSB-first: opcode[2:0], pop_prev, pop_next, push_prev, push_next, reset_reg[7], uop_bgn (UPC_W), uop_end (UPC_W+1), iter_out, iter_in, dst_f_out, dst_f_in, src_f_out, src_f_in, wgt_f_out, wgt_f_in.
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer accepts beat.
- out_upc  out  UPC_W  micro-op address.
- out_dst  out  ACC_IDX_W  dst_off_out + dst_off_in, mod 2^ACC_IDX_W.
- out_src  out  INP_IDX_W  src offset sum, same rule.
- out_wgt  out  WGT_IDX_W  wgt offset sum, same rule.
- out_reset  out  1  latched reset_reg.
- out_last  out  1  final beat of the instruction.
- done  out  1  one-cycle completion pulse.
- stall_cycles  out  32  back-pressure counter (see Configuration).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: insn_ready=1 and out_valid=0.
  - On insn_valid&&insn_ready, latch all fields and clear upc=uop_bgn, iter_in=iter_out=0, and all six offsets to 0.
  - If uop_end≤uop_bgn, iter_in==0 or iter_out==0: go to DONE (zero beats). Otherwise go to RUN.
- RUN: out_valid=1 and outputs driven from registers. Outputs hold stable while out_valid&&!out_ready.
- Advance on handshake (out_valid&&out_ready):
  - end_upc = (upc+1 == uop_end). Compare at UPC_W+1 bits so that uop_end = 2^UPC_W is legal.
  - end_in = (iter_in+1 == iter_in_cfg); end_out = (iter_out+1 == iter_out_cfg).
  - !end_upc: upc+1.
  - end_upc && !end_in: upc=bgn, iter_in+1, *_off_in += *_f_in.
  - end_upc && end_in && !end_out: upc=bgn, iter_in=0, *_off_in=0, iter_out+1, *_off_out += *_f_out.
  - All three end flags set: this is the last beat (out_last=1). Go to DONE.
- DONE: done=1 for one cycle, then IDLE; all loop registers hold their last values.
- Total beats = (uop_end−uop_bgn)·iter_in·iter_out.
- Offset adds wrap silently modulo the channel width; there is no saturation.

## Timing
- Reset values: insn_ready=1, out_valid=0, done=0, out_last=0, out_reset=0, out_upc/out_dst/out_src/out_wgt=0, stall_cycles=0. State is IDLE.
- Accept at edge T: first out_valid in cycle T+1; upc equals uop_bgn and all offsets are 0.
- Full throughput: one beat per cycle while out_ready=1.
- Last beat accepted at edge L: done=1 during cycle L+1; insn_ready=1 from cycle L+2.
- Zero-beat instruction accepted at T: done in T+1, ready again in T+2, and out_valid never asserts.
- out_valid never drops without a handshake.
- Asynchronous reset mid-RUN aborts immediately to reset values. No done pulse is produced.
- insn is sampled only at the accept edge; changes at other times are ignored.

## Configuration
- UOP_LOOP_PERF_EN defined:
  - stall_cycles increments in every RUN cycle with out_valid&&!out_ready.
  - It saturates at 2^32−1, clears on instruction accept, and holds through DONE/IDLE.
- UOP_LOOP_PERF_EN undefined: stall_cycles is tied to 0 and no counter logic is built.

## Structure
- Package gemm_uop_pkg holds:
  - Field-offset localparams derived from the width parameters.
  - The FSM state enum (IDLE/RUN/DONE).
  - Default width constants shared with the datapath.
- Sub-module loop_offset_acc, instantiated three times (dst/src/wgt, parametrised by width):
  - Holds the out/in offset pair with clear, step_in, step_out and wrap_in controls.
  - Produces the summed output offset.

## Test plan
- Instruction bgn=4, end=7, iter_in=2, iter_out=2, dst_f_in=1, dst_f_out=10, out_ready=1.
  - Expect 12 beats, upc sequence 4,5,6 repeated.
  - Expect out_dst sequence 0,0,0,1,1,1,10,10,10,11,11,11.
  - Expect out_last on beat 12 and done one cycle later.
- Same instruction with out_ready toggling every cycle.
  - Expect identical beat sequence with outputs held during stalls.
  - With PERF_EN: expect stall_cycles=12 at done.
- iter_in=0 (also test bgn=end=5).
  - Expect no out_valid, done at T+1, insn_ready at T+2.
- wgt_f_in=1023, WGT_IDX_W=10, iter_in=3, one uop.
  - Expect out_wgt 0,1023,1022 (wrap).
- bgn=8190, end=8192, UPC_W=13.
  - Expect upc 8190,8191 with no compare overflow.
- Assert rst low during beat 5 of a 12-beat run.
  - Expect immediate reset values and no done pulse.
  - A following instruction runs correctly from upc=bgn.
